// File: rtl/dds_phase_gen.sv
// Phase-accumulator address generator for a DDS lookup table.
// Double-buffered tuning word, programmable sample divider, phase offset and sync restart.
module dds_phase_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              en_i,
  input  logic [ACC_W-1:0]  ftw_i,
  input  logic              ftw_load_i,
  input  logic [ADDR_W-1:0] phase_ofs_i,
  input  logic [DIV_W-1:0]  sample_div_i,
  input  logic              sync_i,
  output logic [ADDR_W-1:0] Address,
  output logic              addr_valid_o,
  output logic              wrap_o,
  output logic [ACC_W-1:0]  ftw_active_o,
  output logic              ftw_pending_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             state_next;
  logic               tick_c;
  logic [ACC_W:0]     sum_c;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_pend;
  logic [DIV_W-1:0]   div_cnt;

  // State register
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and sample tick; sync suppresses a coincident tick
  always_comb begin
    state_next = state;
    tick_c     = 1'b0;
    sum_c      = {1'b0, acc} + {1'b0, ftw_active_o};
    case (state)
      IDLE: if (en_i) state_next = RUN;
      RUN: begin
        if (!en_i) state_next = IDLE;
        tick_c = en_i && (div_cnt >= sample_div_i) && !sync_i;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, divider and address output
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      acc          <= '0;
      div_cnt      <= '0;
      Address      <= '0;
      addr_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
    end else if (sync_i) begin
      acc          <= '0;
      div_cnt      <= '0;
      Address      <= phase_ofs_i;
      addr_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
    end else if (tick_c) begin
      acc          <= sum_c[ACC_W-1:0];
      div_cnt      <= '0;
      Address      <= sum_c[ACC_W-1 -: ADDR_W] + phase_ofs_i;
      addr_valid_o <= 1'b1;
      wrap_o       <= sum_c[ACC_W];
    end else begin
      addr_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
      if (state == RUN) div_cnt <= div_cnt + DIV_W'(1);
      else              div_cnt <= '0;
    end
  end

  // Tuning word double buffer: the add on a tick always uses the old active word
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      ftw_active_o  <= '0;
      ftw_pend      <= '0;
      ftw_pending_o <= 1'b0;
    end else if (tick_c) begin
      if (ftw_load_i)         ftw_active_o <= ftw_i;
      else if (ftw_pending_o) ftw_active_o <= ftw_pend;
      ftw_pending_o <= 1'b0;
    end else if (ftw_load_i) begin
      ftw_pend      <= ftw_i;
      ftw_pending_o <= 1'b1;
    end
  end

endmodule
